// File: rtl/mem_access_ctrl_if.sv
// Request/response and SRAM pin bundle for the LC-3 memory access sequencer.
// The master side is the control unit plus the board-level SRAM; the slave side is the sequencer.
interface mem_access_ctrl_if;
  logic        Req_Rd;
  logic        Req_Wr;
  logic [15:0] Addr;
  logic [15:0] Wr_Data;
  logic [15:0] Rd_Data;
  logic        Done;
  logic        Busy;
  logic [15:0] Switches;
  logic [15:0] Hex_Out;
  logic [19:0] Mem_ADDR;
  logic [15:0] Mem_Data_Out;
  logic        Mem_Data_Drive;
  logic [15:0] Mem_Data_In;
  logic        Mem_CE;
  logic        Mem_UB;
  logic        Mem_LB;
  logic        Mem_OE;
  logic        Mem_WE;

  modport master (
    output Req_Rd, Req_Wr, Addr, Wr_Data, Switches, Mem_Data_In,
    input  Rd_Data, Done, Busy, Hex_Out, Mem_ADDR, Mem_Data_Out, Mem_Data_Drive,
    input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );

  modport slave (
    input  Req_Rd, Req_Wr, Addr, Wr_Data, Switches, Mem_Data_In,
    output Rd_Data, Done, Busy, Hex_Out, Mem_ADDR, Mem_Data_Out, Mem_Data_Drive,
    output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-word async SRAM sequencer with programmable OE/WE wait states and one IO address.
// Strobes are decoded purely from the state register; requests are only sampled in IDLE.
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input logic             Clk,
  input logic             Reset,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, RD_ACCESS, WR_SETUP, WR_PULSE, WR_HOLD, DONE
  } state_t;

  state_t      state, state_next;
  logic [2:0]  wait_cnt;
  logic [15:0] addr_q, wdata_q, rd_data_q, hex_q;
  logic        wait_last, io_hit, accept;

  assign wait_last = (wait_cnt == 3'(WAIT_CYCLES));
  assign io_hit    = (bus.Addr == IO_ADDR);
  assign accept    = (state == IDLE) && (bus.Req_Rd || bus.Req_Wr);

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next         = state;
    bus.Mem_CE         = 1'b1;
    bus.Mem_OE         = 1'b1;
    bus.Mem_WE         = 1'b1;
    bus.Mem_Data_Drive = 1'b0;
    bus.Done           = 1'b0;
    bus.Busy           = (state != IDLE);
    case (state)
      IDLE: begin
        // Write has priority; the simultaneous read is discarded.
        if (bus.Req_Wr)      state_next = io_hit ? DONE : WR_SETUP;
        else if (bus.Req_Rd) state_next = io_hit ? DONE : RD_ACCESS;
      end
      RD_ACCESS: begin
        bus.Mem_CE = 1'b0;
        bus.Mem_OE = 1'b0;
        if (wait_last) state_next = DONE;
      end
      WR_SETUP: begin
        bus.Mem_CE         = 1'b0;
        bus.Mem_Data_Drive = 1'b1;
        state_next         = WR_PULSE;
      end
      WR_PULSE: begin
        bus.Mem_CE         = 1'b0;
        bus.Mem_WE         = 1'b0;
        bus.Mem_Data_Drive = 1'b1;
        if (wait_last) state_next = WR_HOLD;
      end
      WR_HOLD: begin
        bus.Mem_CE         = 1'b0;
        bus.Mem_Data_Drive = 1'b1;
        state_next         = DONE;
      end
      DONE: begin
        bus.Done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wait_cnt  <= 3'd0;
      addr_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
      rd_data_q <= 16'h0000;
      hex_q     <= 16'h0000;
    end else begin
      // Counter restarts on every state change so each stretched phase begins at zero.
      if ((state == RD_ACCESS || state == WR_PULSE) && state_next == state)
        wait_cnt <= wait_cnt + 3'd1;
      else
        wait_cnt <= 3'd0;
      if (accept) begin
        addr_q  <= bus.Addr;
        wdata_q <= bus.Wr_Data;
        if (io_hit) begin
          if (bus.Req_Wr) hex_q     <= bus.Wr_Data;
          else            rd_data_q <= bus.Switches;
        end
      end
      if (state == RD_ACCESS && wait_last)
        rd_data_q <= bus.Mem_Data_In;
    end
  end

  assign bus.Mem_UB       = bus.Mem_CE;
  assign bus.Mem_LB       = bus.Mem_CE;
  assign bus.Mem_ADDR     = {4'h0, addr_q};
  assign bus.Mem_Data_Out = wdata_q;
  assign bus.Rd_Data      = rd_data_q;
  assign bus.Hex_Out      = hex_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus random traffic against a word-level reference.
module tb_mem_access_ctrl;
  localparam int          W  = 1;
  localparam logic [15:0] IO = 16'hFFFF;

  logic Clk, Reset;
  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.WAIT_CYCLES(W), .IO_ADDR(IO)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [15:0] init_val(int i);
    return (i == 32'h30) ? 16'h1234 : 16'(i * 291 + 256);
  endfunction

  // Board SRAM: 1K words, written on a clock edge while CE, WE are low with the bus driven.
  logic [15:0] sram [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) sram[i] = init_val(i);
    forever begin
      @(posedge Clk);
      if (!bus.Mem_CE && !bus.Mem_WE && bus.Mem_Data_Drive)
        sram[bus.Mem_ADDR[9:0]] = bus.Mem_Data_Out;
    end
  end
  assign bus.Mem_Data_In = (!bus.Mem_CE && !bus.Mem_OE) ? sram[bus.Mem_ADDR[9:0]] : 16'hDEAD;

  int errors = 0;
  int checks = 0;
  logic [15:0] ref_mem [0:1023];
  logic [15:0] ref_rd, ref_hex;
  int m_done, m_oe, m_we, m_drv, m_ce, m_inv, m_addr, m_busy, m_extra;

  // Issue one request and observe every cycle until Done, plus two idle cycles afterwards.
  task run_access(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                  input int pulse_at);
    @(negedge Clk);
    bus.Req_Rd = rd; bus.Req_Wr = wr; bus.Addr = a; bus.Wr_Data = d;
    @(posedge Clk); #1;
    bus.Req_Rd = 1'b0; bus.Req_Wr = 1'b0;
    bus.Addr = 16'($urandom); bus.Wr_Data = 16'($urandom);
    m_done = 0; m_oe = 0; m_we = 0; m_drv = 0; m_ce = 0;
    m_inv = 0; m_addr = 0; m_busy = 0; m_extra = 0;
    for (int k = 1; k <= 20 && m_done == 0; k++) begin
      if (!bus.Mem_OE) m_oe++;
      if (!bus.Mem_WE) m_we++;
      if (!bus.Mem_CE) m_ce++;
      if (bus.Mem_Data_Drive) m_drv++;
      if (!bus.Mem_OE && !bus.Mem_WE) m_inv++;
      if (bus.Mem_Data_Drive && !bus.Mem_OE) m_inv++;
      if (bus.Mem_Data_Drive && bus.Mem_Data_Out !== d) m_inv++;
      if (bus.Mem_UB !== bus.Mem_CE || bus.Mem_LB !== bus.Mem_CE) m_inv++;
      if (bus.Mem_ADDR !== {4'h0, a}) m_addr++;
      if (bus.Busy !== 1'b1) m_busy++;
      if (bus.Done === 1'b1) m_done = k;
      if (k == pulse_at) begin
        bus.Req_Rd = 1'b1;
        bus.Addr   = 16'($urandom);
      end
      @(posedge Clk); #1;
      bus.Req_Rd = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      if (bus.Done !== 1'b0) m_extra++;
      if (bus.Busy !== 1'b0) m_busy++;
      if (bus.Mem_CE !== 1'b1 || bus.Mem_Data_Drive !== 1'b0) m_inv++;
      @(posedge Clk); #1;
    end
  endtask

  task test_reset;
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy_held got=%b want=0", bus.Busy); end
    checks++; if (bus.Mem_WE !== 1'b1) begin errors++; $display("FAIL reset_we_held got=%b want=1", bus.Mem_WE); end
    @(negedge Clk); Reset = 1'b0;
    @(posedge Clk); #1;
    checks++;
    if ({bus.Mem_CE, bus.Mem_UB, bus.Mem_LB, bus.Mem_OE, bus.Mem_WE} !== 5'b11111) begin
      errors++;
      $display("FAIL reset_strobes got=%b want=11111",
               {bus.Mem_CE, bus.Mem_UB, bus.Mem_LB, bus.Mem_OE, bus.Mem_WE});
    end
    checks++; if (bus.Mem_Data_Drive !== 1'b0) begin errors++; $display("FAIL reset_drive got=%b want=0", bus.Mem_Data_Drive); end
    checks++; if (bus.Rd_Data !== 16'h0) begin errors++; $display("FAIL reset_rd_data got=%h want=0000", bus.Rd_Data); end
    checks++; if (bus.Hex_Out !== 16'h0) begin errors++; $display("FAIL reset_hex got=%h want=0000", bus.Hex_Out); end
    checks++; if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b%b want=00", bus.Busy, bus.Done); end
  endtask

  task test_sram_read;
    run_access(1'b1, 1'b0, 16'h0030, 16'h0000, 0);
    ref_rd = ref_mem[10'h030];
    checks++; if (m_done !== W + 2) begin errors++; $display("FAIL rd_done_cycle got=%0d want=%0d", m_done, W + 2); end
    checks++; if (m_oe !== W + 1) begin errors++; $display("FAIL rd_oe_cycles got=%0d want=%0d", m_oe, W + 1); end
    checks++; if (m_we !== 0) begin errors++; $display("FAIL rd_we_cycles got=%0d want=0", m_we); end
    checks++; if (m_addr !== 0) begin errors++; $display("FAIL rd_mem_addr bad_cycles=%0d want=0", m_addr); end
    checks++; if (bus.Rd_Data !== 16'h1234) begin errors++; $display("FAIL rd_data got=%h want=1234", bus.Rd_Data); end
    checks++; if (m_inv + m_busy + m_extra !== 0) begin errors++; $display("FAIL rd_protocol inv=%0d busy=%0d extra=%0d want=0", m_inv, m_busy, m_extra); end
  endtask

  task test_sram_write;
    run_access(1'b0, 1'b1, 16'h0031, 16'hBEEF, 0);
    ref_mem[10'h031] = 16'hBEEF;
    checks++; if (m_done !== W + 4) begin errors++; $display("FAIL wr_done_cycle got=%0d want=%0d", m_done, W + 4); end
    checks++; if (m_we !== W + 1) begin errors++; $display("FAIL wr_we_cycles got=%0d want=%0d", m_we, W + 1); end
    checks++; if (m_drv !== W + 3 || m_oe !== 0) begin errors++; $display("FAIL wr_drive_oe drv=%0d oe=%0d want=%0d/0", m_drv, m_oe, W + 3); end
    checks++; if (sram[10'h031] !== 16'hBEEF) begin errors++; $display("FAIL wr_sram_word got=%h want=beef", sram[10'h031]); end
    checks++; if (bus.Rd_Data !== ref_rd) begin errors++; $display("FAIL wr_rd_data_hold got=%h want=%h", bus.Rd_Data, ref_rd); end
    checks++; if (m_inv + m_addr + m_busy + m_extra !== 0) begin errors++; $display("FAIL wr_protocol inv=%0d addr=%0d busy=%0d extra=%0d want=0", m_inv, m_addr, m_busy, m_extra); end
  endtask

  task test_io;
    bus.Switches = 16'h5A5A;
    run_access(1'b0, 1'b1, IO, 16'h00A5, 0);
    ref_hex = 16'h00A5;
    checks++; if (m_done !== 1 || m_ce !== 0) begin errors++; $display("FAIL io_wr_timing done=%0d ce=%0d want=1/0", m_done, m_ce); end
    checks++; if (bus.Hex_Out !== 16'h00A5) begin errors++; $display("FAIL io_hex got=%h want=00a5", bus.Hex_Out); end
    run_access(1'b1, 1'b0, IO, 16'h0000, 0);
    ref_rd = 16'h5A5A;
    checks++; if (m_done !== 1 || m_ce !== 0) begin errors++; $display("FAIL io_rd_timing done=%0d ce=%0d want=1/0", m_done, m_ce); end
    checks++; if (bus.Rd_Data !== 16'h5A5A) begin errors++; $display("FAIL io_rd_data got=%h want=5a5a", bus.Rd_Data); end
    checks++; if (bus.Hex_Out !== 16'h00A5 || m_extra !== 0) begin errors++; $display("FAIL io_hex_hold got=%h extra=%0d want=00a5/0", bus.Hex_Out, m_extra); end
  endtask

  task test_both_requests;
    logic [15:0] d;
    d = 16'($urandom);
    run_access(1'b1, 1'b1, 16'h0050, d, 2);
    ref_mem[10'h050] = d;
    checks++; if (m_done !== W + 4 || m_oe !== 0) begin errors++; $display("FAIL both_write_wins done=%0d oe=%0d want=%0d/0", m_done, m_oe, W + 4); end
    checks++; if (m_extra !== 0 || m_busy !== 0) begin errors++; $display("FAIL both_ignored_req extra=%0d busy=%0d want=0/0", m_extra, m_busy); end
    checks++; if (sram[10'h050] !== d || bus.Rd_Data !== ref_rd) begin errors++; $display("FAIL both_data sram=%h rd=%h want=%h/%h", sram[10'h050], bus.Rd_Data, d, ref_rd); end
    run_access(1'b1, 1'b0, 16'h0050, 16'h0000, W + 2);
    ref_rd = d;
    checks++; if (bus.Rd_Data !== d || m_extra !== 0 || m_busy !== 0) begin errors++; $display("FAIL done_cycle_req rd=%h extra=%0d busy=%0d want=%h/0/0", bus.Rd_Data, m_extra, m_busy, d); end
  endtask

  task test_reset_mid_write;
    int dones;
    @(negedge Clk);
    bus.Req_Wr = 1'b1; bus.Addr = 16'h0040; bus.Wr_Data = 16'h7777;
    @(posedge Clk); #1;
    bus.Req_Wr = 1'b0;
    @(posedge Clk); #1;
    checks++; if (bus.Mem_WE !== 1'b0) begin errors++; $display("FAIL abort_in_pulse we=%b want=0", bus.Mem_WE); end
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    ref_rd = 16'h0; ref_hex = 16'h0;
    checks++; if (bus.Mem_WE !== 1'b1 || bus.Mem_CE !== 1'b1 || bus.Mem_Data_Drive !== 1'b0) begin errors++; $display("FAIL abort_strobes we=%b ce=%b drv=%b want=1/1/0", bus.Mem_WE, bus.Mem_CE, bus.Mem_Data_Drive); end
    checks++; if (bus.Busy !== 1'b0 || bus.Rd_Data !== 16'h0 || bus.Hex_Out !== 16'h0) begin errors++; $display("FAIL abort_regs busy=%b rd=%h hex=%h want=0/0000/0000", bus.Busy, bus.Rd_Data, bus.Hex_Out); end
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.Done !== 1'b0) dones++;
      @(posedge Clk); #1;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL abort_no_done got=%0d want=0", dones); end
    run_access(1'b1, 1'b0, 16'h0031, 16'h0000, 0);
    ref_rd = ref_mem[10'h031];
    checks++; if (m_done !== W + 2 || bus.Rd_Data !== ref_rd) begin errors++; $display("FAIL abort_then_read done=%0d rd=%h want=%0d/%h", m_done, bus.Rd_Data, W + 2, ref_rd); end
  endtask

  task test_random;
    int op, pa, e_done, e_oe, e_we, e_drv, e_ce;
    logic rd, wr, io;
    logic [15:0] a, d, sw;
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 4);
      rd = (op == 0 || op == 2 || op == 4);
      wr = (op == 1 || op == 3 || op == 4);
      a  = (op == 2 || op == 3) ? IO : 16'h0100 + 16'($urandom_range(0, 255));
      io = (a == IO);
      d  = 16'($urandom);
      sw = 16'($urandom);
      pa = $urandom_range(0, 6);
      bus.Switches = sw;
      if (wr) begin
        e_done = io ? 1 : W + 4; e_we = io ? 0 : W + 1; e_drv = io ? 0 : W + 3;
        e_oe = 0; e_ce = io ? 0 : W + 3;
        if (io) ref_hex = d; else ref_mem[a[9:0]] = d;
      end else begin
        e_done = io ? 1 : W + 2; e_oe = io ? 0 : W + 1; e_we = 0; e_drv = 0;
        e_ce = io ? 0 : W + 1;
        ref_rd = io ? sw : ref_mem[a[9:0]];
      end
      run_access(rd, wr, a, d, pa);
      checks++; if (m_done !== e_done) begin errors++; $display("FAIL rnd%0d_done got=%0d want=%0d", n, m_done, e_done); end
      checks++; if (m_oe !== e_oe || m_we !== e_we) begin errors++; $display("FAIL rnd%0d_oe_we got=%0d/%0d want=%0d/%0d", n, m_oe, m_we, e_oe, e_we); end
      checks++; if (m_ce !== e_ce || m_drv !== e_drv) begin errors++; $display("FAIL rnd%0d_ce_drv got=%0d/%0d want=%0d/%0d", n, m_ce, m_drv, e_ce, e_drv); end
      checks++; if (m_inv + m_addr + m_busy + m_extra !== 0) begin errors++; $display("FAIL rnd%0d_protocol inv=%0d addr=%0d busy=%0d extra=%0d want=0", n, m_inv, m_addr, m_busy, m_extra); end
      checks++; if (bus.Rd_Data !== ref_rd) begin errors++; $display("FAIL rnd%0d_rd_data got=%h want=%h", n, bus.Rd_Data, ref_rd); end
      checks++; if (bus.Hex_Out !== ref_hex) begin errors++; $display("FAIL rnd%0d_hex got=%h want=%h", n, bus.Hex_Out, ref_hex); end
      if (wr && !io) begin
        checks++; if (sram[a[9:0]] !== d) begin errors++; $display("FAIL rnd%0d_sram got=%h want=%h", n, sram[a[9:0]], d); end
      end
    end
  endtask

  initial begin
    Reset = 1'b1;
    bus.Req_Rd = 1'b0; bus.Req_Wr = 1'b0;
    bus.Addr = 16'h0; bus.Wr_Data = 16'h0; bus.Switches = 16'h0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    ref_rd = 16'h0; ref_hex = 16'h0;
    test_reset;
    test_sram_read;
    test_sram_write;
    test_io;
    test_both_requests;
    test_reset_mid_write;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory/IO access sequencer between the LC-3 control unit and the external 16-bit asynchronous SRAM.
- Accepts single-word read/write requests, generates SRAM strobe timing with programmable wait states, and returns read data plus a one-cycle Done pulse.
- Decodes one memory-mapped IO address: reads return the switches, writes update the hex display register; the SRAM is not touched for that address.

Parameters:
- WAIT_CYCLES, 1, extra cycles OE/WE held low beyond the minimum 1 (range 0..7).
- IO_ADDR, 16'hFFFF, memory-mapped IO address.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high
- Req_Rd  in  1  read request, sampled only in IDLE
- Req_Wr  in  1  write request, sampled only in IDLE
- Addr  in  16  request address
- Wr_Data  in  16  write data
- Rd_Data  out  16  registered read data; holds until the next read completes
- Done  out  1  one-cycle pulse: access complete
- Busy  out  1  high whenever state != IDLE
- Switches  in  16  IO read source
- Hex_Out  out  16  IO write register
- Mem_ADDR  out  20  SRAM address, {4'b0, latched Addr}
- Mem_Data_Out  out  16  SRAM write data (latched Wr_Data)
- Mem_Data_Drive  out  1  tri-state enable for the SRAM data bus (top level builds the inout)
- Mem_Data_In  in  16  SRAM read data
- Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  SRAM controls, active low

Behaviour:
- Reset (synchronous, active-high, takes effect at the next Clk edge):
  - state = IDLE.
  - Mem_CE/UB/LB/OE/WE = 1; Mem_Data_Drive = 0.
  - Rd_Data = 0, Hex_Out = 0, Done = 0, Busy = 0, latched address/data = 0.
- States: IDLE, RD_ACCESS, WR_SETUP, WR_PULSE, WR_HOLD, DONE. Wait counter is 3 bits.
- IDLE:
  - On Req_Wr or Req_Rd, latch Addr and Wr_Data at the edge.
  - Both asserted: write wins and the read is dropped.
  - Requests outside IDLE (including the DONE cycle) are ignored; there is no queueing.
- IO path, when latched address == IO_ADDR at acceptance:
  - Read: Rd_Data <= Switches at the accept edge.
  - Write: Hex_Out <= Wr_Data at the accept edge.
  - Next state DONE. No SRAM strobe is asserted.
- SRAM read, request accepted in cycle T:
  - T+1 .. T+1+WAIT_CYCLES: RD_ACCESS with Mem_CE=0, UB=LB=0, OE=0.
  - Rd_Data <= Mem_Data_In at the edge ending the last RD_ACCESS cycle.
  - T+2+WAIT_CYCLES: DONE.
- SRAM write, request accepted in cycle T:
  - T+1: WR_SETUP with CE=0, UB=LB=0, WE=1, Drive=1.
  - T+2 .. T+2+WAIT_CYCLES: WR_PULSE with WE=0, Drive=1.
  - T+3+WAIT_CYCLES: WR_HOLD with WE=1, Drive=1, CE=0.
  - T+4+WAIT_CYCLES: DONE.
- DONE: Done=1, Busy=1, all strobes inactive, Drive=0; next state IDLE unconditionally.
- Strobe invariants:
  - OE and WE are never both low.
  - Drive=1 only in WR_* states; OE=1 whenever Drive=1.
  - Mem_ADDR is stable from the cycle after acceptance through DONE.
- All outputs are decoded from registered state and registers only; no combinational path from request inputs to SRAM controls.
- Reset during any access: aborted at the next edge; WE/OE return high, no Done pulse, Rd_Data/Hex_Out cleared.
- WAIT_CYCLES=0: RD_ACCESS and WR_PULSE last exactly 1 cycle.

Test Plan:
1. Reset held 2 cycles, then released -> all Mem_* controls 1, Drive=0, Rd_Data=0, Hex_Out=0, Busy=0, Done=0.
2. WAIT_CYCLES=1, Req_Rd Addr=16'h0030, SRAM model returns 16'h1234 -> Mem_ADDR=20'h00030, OE low for 2 cycles, Done at T+3, Rd_Data=16'h1234, WE high throughout.
3. WAIT_CYCLES=1, Req_Wr Addr=16'h0031, Wr_Data=16'hBEEF -> WE low exactly 2 cycles bracketed by 1 setup and 1 hold cycle with Drive=1, Done at T+5, SRAM model holds 16'hBEEF at 0x0031.
4. Req_Wr to 16'hFFFF data 16'h00A5, then Req_Rd to 16'hFFFF with Switches=16'h5A5A -> Hex_Out=16'h00A5 and Done at T+1 each; Rd_Data=16'h5A5A; CE stays 1 throughout.
5. Req_Rd and Req_Wr together, then a new Req_Rd pulsed mid-access -> only the write executes; the mid-access request is ignored; exactly one Done pulse.
6. Reset asserted during WR_PULSE -> WE returns high at the next edge, no Done, state IDLE; a subsequent read of 0x0031 works normally.
